// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line in, last good byte out
`timescale 1ns/1ps
interface uart_receiver_if;
    logic       uart_rx;
    logic [7:0] Out;
    modport master (output uart_rx, input Out);
    modport slave (input uart_rx, output Out);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver with inverted idle/start/stop levels (idle 0, start 1, stop 0)
// Ports: clk, rst_n (sync, active-high), bus.uart_rx (async line), bus.Out (last good byte)
`timescale 1ns/1ps
module uart_receiver #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200
) (
    input logic            clk,
    input logic            rst_n,
    uart_receiver_if.slave bus
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_m, rx_s;
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            bus.Out <= '0;
            rx_m    <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_m <= bus.uart_rx;
            rx_s <= rx_m;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (rx_s) state <= START;
                end
                START: begin
                    // confirm the start bit at its midpoint; shorter pulses are glitches
                    clk_cnt <= (clk_cnt == HALF) ? '0 : clk_cnt + 1'b1;
                    if (clk_cnt == HALF) state <= rx_s ? DATA : IDLE;
                end
                DATA: begin
                    clk_cnt <= (clk_cnt == LAST) ? '0 : clk_cnt + 1'b1;
                    if (clk_cnt == LAST) begin
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    clk_cnt <= (clk_cnt == LAST) ? '0 : clk_cnt + 1'b1;
                    if (clk_cnt == LAST) begin
                        if (!rx_s) bus.Out <= shreg;
                        state <= rx_s ? WAIT_IDLE : IDLE;
                    end
                end
                WAIT_IDLE: if (!rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam int BIT = 8680;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [7:0] last_out = 8'h00;
    logic [7:0] q[$];
    uart_receiver_if bus();
    uart_receiver dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #10 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (mon_en && bus.Out !== last_out) begin
            if (q.size() != 0) check("out", 32'(bus.Out), 32'(q.pop_front()));
            else check("unexpected_out", 32'(bus.Out), 32'(last_out));
            last_out = bus.Out;
        end
    end
    task automatic send(input logic [7:0] d, input logic stop);
        bus.uart_rx = 1'b1;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = d[i];
            #BIT;
        end
        bus.uart_rx = stop;
        #BIT;
    endtask
    task automatic drain(input string tag);
        for (int i = 0; i < 3 * 434 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check(tag, 32'(q.size()), 0);
    endtask
    initial begin
        bus.uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_out", 32'(bus.Out), 0);
        check("rst_state", 32'(dut.state), 0);
        rst_n = 1'b0;
        #1000;
        check("idle_out", 32'(bus.Out), 0);
        mon_en = 1'b1;
        q.push_back(8'h5A);
        send(8'h5A, 1'b0);
        drain("drain_5a");
        #(2 * BIT);
        q.push_back(8'hA3);
        send(8'hA3, 1'b0);
        drain("drain_a3");
        #(2 * BIT);
        q.push_back(8'hB3);
        send(8'hB3, 1'b0);
        drain("drain_b3");
        #(2 * BIT);
        q.push_back(8'h3C);
        q.push_back(8'hC3);
        send(8'h3C, 1'b0);
        send(8'hC3, 1'b0);
        drain("drain_b2b");
        #(2 * BIT);
        bus.uart_rx = 1'b1;
        #100;
        bus.uart_rx = 1'b0;
        #(2 * BIT);
        check("glitch", 32'(bus.Out), 32'h C3);
        send(8'h55, 1'b1);
        #(2 * BIT);
        bus.uart_rx = 1'b0;
        #BIT;
        check("frame_err", 32'(bus.Out), 32'h C3);
        q.push_back(8'h81);
        send(8'h81, 1'b0);
        drain("drain_81");
        #(2 * BIT);
        bus.uart_rx = 1'b1;
        #BIT;
        for (int i = 0; i < 4; i++) begin
            bus.uart_rx = i[0];
            #BIT;
        end
        bus.uart_rx = 1'b1;
        #(BIT / 2);
        q.push_back(8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bus.uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        check("mid_rst_state", 32'(dut.state), 0);
        drain("drain_mid_rst");
        #BIT;
        q.push_back(8'hF0);
        send(8'hF0, 1'b0);
        drain("drain_f0");
        #(2 * BIT);
        check("final_out", 32'(bus.Out), 32'h F0);
        check("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
